record_player: RTL and testbench

- Playback sequencer for the note record memory; it reads the memory that the recording path writes.
- On start, it walks entries 0..len-1 through the memory's rw/en/cnt read interface and latches each entry (octave, note, length, full_note).
- It drives each note to the tone generator for a duration derived from length and full_note, with an optional silent gap between notes.
- It sits between the mode controller (start/stop/len) and the buzzer tone generator.

---
 rtl/record_player_pkg.sv | 39 +++
 rtl/record_player_if.sv | 24 ++
 rtl/record_player_tick_timer.sv | 47 ++++
 rtl/record_player.sv | 145 ++++++++++++++
 tb/tb_record_player.sv | 460 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/record_player_pkg.sv
// Shared widths, timing defaults, player state encoding and the
// note-duration helper for the record playback sequencer.
package record_player_pkg;

    localparam int REC_CNT_BITS   = 3;
    localparam int OCTAVE_BITS    = 3;
    localparam int NOTE_BITS      = 4;
    localparam int LENGTH_BITS    = 3;
    localparam int FULL_NOTE_BITS = 8;

    localparam int PLAY_TICK_DIV  = 50000;
    localparam int PLAY_GAP_TICKS = 10;

    typedef enum logic [2:0] {
        PS_IDLE  = 3'd0,
        PS_ADDR  = 3'd1,
        PS_FETCH = 3'd2,
        PS_LATCH = 3'd3,
        PS_PLAY  = 3'd4,
        PS_GAP   = 3'd5,
        PS_NEXT  = 3'd6,
        PS_FIN   = 3'd7
    } player_state_t;

    // Note length in ticks: the whole-note tick count divided by 2^length,
    // never shorter than one tick so every entry is audible/visible.
    function automatic logic [FULL_NOTE_BITS-1:0] note_duration(
        input logic [FULL_NOTE_BITS-1:0] full_note,
        input logic [LENGTH_BITS-1:0]    length
    );
        logic [FULL_NOTE_BITS-1:0] d;
        d = full_note >> length;
        if (d == '0) begin
            d = FULL_NOTE_BITS'(1);
        end
        return d;
    endfunction

endpackage

// File: rtl/record_player_if.sv
// Read port of the note record memory. The player is the master that
// drives direction/enable/index; the memory returns registered data.
interface record_player_if;
    import record_player_pkg::*;

    logic                      rw;
    logic                      en;
    logic [REC_CNT_BITS-1:0]   cnt;
    logic [OCTAVE_BITS-1:0]    octave_r;
    logic [NOTE_BITS-1:0]      note_r;
    logic [LENGTH_BITS-1:0]    length_r;
    logic [FULL_NOTE_BITS-1:0] full_note_r;

    modport master (
        output rw, en, cnt,
        input  octave_r, note_r, length_r, full_note_r
    );

    modport slave (
        input  rw, en, cnt,
        output octave_r, note_r, length_r, full_note_r
    );

endinterface

// File: rtl/record_player_tick_timer.sv
// Prescaler plus tick down-counter. A load restarts the prescaler and sets
// the tick count; tc is high on the last clock of the last tick.
module record_player_tick_timer #(
    parameter int TICK_DIV = 4,
    parameter int CNT_BITS = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clear,
    input  logic                load,
    input  logic [CNT_BITS-1:0] load_val,
    output logic                tc
);

    localparam int PRE_BITS = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_BITS-1:0] PRE_LAST = PRE_BITS'(TICK_DIV - 1);

    logic [PRE_BITS-1:0] pre_reg;
    logic [CNT_BITS-1:0] cnt_reg;
    logic                tick;

    assign tick = (pre_reg == PRE_LAST);
    assign tc   = tick && (cnt_reg == CNT_BITS'(1));

    // Prescaler wraps every TICK_DIV clocks and decrements the tick count;
    // an empty counter holds still so tc cannot fire spuriously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_reg <= '0;
            cnt_reg <= '0;
        end else if (clear) begin
            pre_reg <= '0;
            cnt_reg <= '0;
        end else if (load) begin
            pre_reg <= '0;
            cnt_reg <= load_val;
        end else if (cnt_reg != '0) begin
            if (tick) begin
                pre_reg <= '0;
                cnt_reg <= cnt_reg - CNT_BITS'(1);
            end else begin
                pre_reg <= pre_reg + PRE_BITS'(1);
            end
        end
    end

endmodule

// File: rtl/record_player.sv
// Playback sequencer: walks record entries 0..len-1 through the memory
// read port, then plays each note for its duration followed by a gap.
module record_player
    import record_player_pkg::*;
#(
    parameter int TICK_DIV  = PLAY_TICK_DIV,
    parameter int GAP_TICKS = PLAY_GAP_TICKS
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   stop,
    input  logic [REC_CNT_BITS:0]  rec_len,
    record_player_if.master        rec,
    output logic [OCTAVE_BITS-1:0] play_octave,
    output logic [NOTE_BITS-1:0]   play_note,
    output logic                   tone_en,
    output logic                   busy,
    output logic                   done
);

    player_state_t             state_reg, state_next;
    logic [REC_CNT_BITS:0]     idx_reg, idx_next;
    logic [REC_CNT_BITS:0]     len_reg, len_next;
    logic [REC_CNT_BITS:0]     idx_inc;
    logic [OCTAVE_BITS-1:0]    oct_reg, oct_next;
    logic [NOTE_BITS-1:0]      note_reg, note_next;
    logic                      tmr_load;
    logic                      tmr_clear;
    logic [FULL_NOTE_BITS-1:0] tmr_val;
    logic                      tmr_tc;

    assign idx_inc = idx_reg + (REC_CNT_BITS + 1)'(1);

    record_player_tick_timer #(
        .TICK_DIV (TICK_DIV),
        .CNT_BITS (FULL_NOTE_BITS)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (tmr_clear),
        .load     (tmr_load),
        .load_val (tmr_val),
        .tc       (tmr_tc)
    );

    // State, index, length and latched note registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= PS_IDLE;
            idx_reg   <= '0;
            len_reg   <= '0;
            oct_reg   <= '0;
            note_reg  <= '0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            len_reg   <= len_next;
            oct_reg   <= oct_next;
            note_reg  <= note_next;
        end
    end

    // Next-state logic and timer control; stop overrides everything.
    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        len_next   = len_reg;
        oct_next   = oct_reg;
        note_next  = note_reg;
        tmr_load   = 1'b0;
        tmr_clear  = 1'b0;
        tmr_val    = '0;
        if (stop) begin
            state_next = PS_IDLE;
            idx_next   = '0;
            len_next   = '0;
            oct_next   = '0;
            note_next  = '0;
            tmr_clear  = 1'b1;
        end else begin
            case (state_reg)
                PS_IDLE: begin
                    if (start) begin
                        len_next   = rec_len;
                        idx_next   = '0;
                        state_next = (rec_len == '0) ? PS_FIN : PS_ADDR;
                    end
                end
                PS_ADDR:  state_next = PS_FETCH;
                PS_FETCH: state_next = PS_LATCH;
                PS_LATCH: begin
                    oct_next   = rec.octave_r;
                    note_next  = rec.note_r;
                    tmr_load   = 1'b1;
                    tmr_val    = note_duration(rec.full_note_r, rec.length_r);
                    state_next = PS_PLAY;
                end
                PS_PLAY: begin
                    if (tmr_tc) begin
                        if (GAP_TICKS == 0) begin
                            state_next = PS_NEXT;
                        end else begin
                            state_next = PS_GAP;
                            tmr_load   = 1'b1;
                            tmr_val    = FULL_NOTE_BITS'(GAP_TICKS);
                        end
                    end
                end
                PS_GAP: begin
                    if (tmr_tc) begin
                        state_next = PS_NEXT;
                    end
                end
                PS_NEXT: begin
                    idx_next   = idx_inc;
                    state_next = (idx_inc == len_reg) ? PS_FIN : PS_ADDR;
                end
                PS_FIN:   state_next = PS_IDLE;
                default:  state_next = PS_IDLE;
            endcase
            // The finishing cycle presents a silent, cleared note.
            if (state_next == PS_FIN) begin
                oct_next  = '0;
                note_next = '0;
            end
        end
    end

    // Moore outputs decoded from the current state and latched note.
    always_comb begin
        rec.rw      = 1'b0;
        rec.en      = (state_reg == PS_FETCH) || (state_reg == PS_LATCH);
        rec.cnt     = '0;
        if ((state_reg == PS_ADDR) || (state_reg == PS_FETCH) || (state_reg == PS_LATCH)) begin
            rec.cnt = idx_reg[REC_CNT_BITS-1:0];
        end
        play_octave = oct_reg;
        play_note   = note_reg;
        tone_en     = (state_reg == PS_PLAY) && (note_reg != '0);
        busy        = (state_reg != PS_IDLE);
        done        = (state_reg == PS_FIN);
    end

endmodule

// File: tb/tb_record_player.sv
// Directed bench for record_player with TICK_DIV=4, GAP_TICKS=1 and a
// registered-read record memory model.
module tb_record_player;
    import record_player_pkg::*;

    localparam int TDIV = 4;
    localparam int GAPT = 1;
    localparam int DEPTH = 2 ** REC_CNT_BITS;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   start = 1'b0;
    logic                   stop = 1'b0;
    logic [REC_CNT_BITS:0]  rec_len = '0;
    logic [OCTAVE_BITS-1:0] play_octave;
    logic [NOTE_BITS-1:0]   play_note;
    logic                   tone_en;
    logic                   busy;
    logic                   done;

    int n_checks = 0;
    int n_fail   = 0;

    logic [OCTAVE_BITS-1:0]    mem_oct  [DEPTH];
    logic [NOTE_BITS-1:0]      mem_note [DEPTH];
    logic [LENGTH_BITS-1:0]    mem_len  [DEPTH];
    logic [FULL_NOTE_BITS-1:0] mem_fn   [DEPTH];

    record_player_if rec();

    record_player #(.TICK_DIV(TDIV), .GAP_TICKS(GAPT)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .stop        (stop),
        .rec_len     (rec_len),
        .rec         (rec),
        .play_octave (play_octave),
        .play_note   (play_note),
        .tone_en     (tone_en),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    // Record memory: data registered on the enabled read edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rec.octave_r    <= '0;
            rec.note_r      <= '0;
            rec.length_r    <= '0;
            rec.full_note_r <= '0;
        end else if (rec.en && !rec.rw) begin
            rec.octave_r    <= mem_oct[rec.cnt];
            rec.note_r      <= mem_note[rec.cnt];
            rec.length_r    <= mem_len[rec.cnt];
            rec.full_note_r <= mem_fn[rec.cnt];
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required finish earlier");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_entry(input logic [REC_CNT_BITS-1:0] i, input logic [OCTAVE_BITS-1:0] o,
                             input logic [NOTE_BITS-1:0] n, input logic [LENGTH_BITS-1:0] l,
                             input logic [FULL_NOTE_BITS-1:0] f);
        mem_oct[i]  = o;
        mem_note[i] = n;
        mem_len[i]  = l;
        mem_fn[i]   = f;
    endtask

    task automatic pulse_start(input logic [REC_CNT_BITS:0] len);
        rec_len = len;
        start   = 1'b1;
        tick;
        start   = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #3;
        n_checks++;
        if ({tone_en, busy, done, rec.en, rec.rw} !== 5'b0 || rec.cnt !== '0 ||
            play_octave !== '0 || play_note !== '0) begin
            n_fail++;
            $display("FAIL reset_defaults: tone=%b busy=%b done=%b en=%b rw=%b cnt=%0d oct=%0d note=%0d, want all 0",
                     tone_en, busy, done, rec.en, rec.rw, rec.cnt, play_octave, play_note);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: busy=%b done=%b, want 0 0", busy, done);
        end
        $display("test_reset: complete");
    endtask

    task automatic test_single_note;
        int cnt;
        set_entry(0, 2, 5, 2, 16);
        pulse_start(1);
        n_checks++;
        if (rec.en !== 1'b0 || busy !== 1'b1 || tone_en !== 1'b0) begin
            n_fail++;
            $display("FAIL single_addr: en=%b busy=%b tone=%b, want 0 1 0", rec.en, busy, tone_en);
        end
        tick;
        n_checks++;
        if (rec.en !== 1'b1 || rec.cnt !== '0 || rec.rw !== 1'b0) begin
            n_fail++;
            $display("FAIL single_fetch: en=%b cnt=%0d rw=%b, want 1 0 0", rec.en, rec.cnt, rec.rw);
        end
        tick;
        n_checks++;
        if (rec.en !== 1'b1 || rec.cnt !== '0 || tone_en !== 1'b0) begin
            n_fail++;
            $display("FAIL single_latch: en=%b cnt=%0d tone=%b, want 1 0 0", rec.en, rec.cnt, tone_en);
        end
        tick;
        n_checks++;
        if (tone_en !== 1'b1 || play_octave !== 3'd2 || play_note !== 4'd5 || rec.en !== 1'b0) begin
            n_fail++;
            $display("FAIL single_play_start: tone=%b oct=%0d note=%0d en=%b, want 1 2 5 0",
                     tone_en, play_octave, play_note, rec.en);
        end
        cnt = 0;
        while (tone_en === 1'b1 && cnt < 100) begin
            cnt++;
            tick;
        end
        n_checks++;
        if (cnt != 16) begin
            n_fail++;
            $display("FAIL single_tone_len: %0d cycles, want 16", cnt);
        end
        n_checks++;
        if (play_octave !== 3'd2 || play_note !== 4'd5) begin
            n_fail++;
            $display("FAIL single_gap_hold: oct=%0d note=%0d, want 2 5", play_octave, play_note);
        end
        cnt = 0;
        while (done !== 1'b1 && tone_en !== 1'b1 && cnt < 100) begin
            cnt++;
            tick;
        end
        n_checks++;
        if (cnt != 5) begin
            n_fail++;
            $display("FAIL single_silent_len: %0d cycles before done, want 5 (gap 4 + next 1)", cnt);
        end
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b1 || play_note !== '0 || play_octave !== '0) begin
            n_fail++;
            $display("FAIL single_fin: done=%b busy=%b oct=%0d note=%0d, want 1 1 0 0",
                     done, busy, play_octave, play_note);
        end
        tick;
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL single_idle: done=%b busy=%b, want 0 0", done, busy);
        end
        $display("test_single_note: complete");
    endtask

    task automatic test_rest_min;
        int cnt;
        set_entry(0, 1, 0, 3, 16);
        set_entry(1, 4, 3, 7, 16);
        pulse_start(2);
        cnt = 0;
        while (tone_en !== 1'b1 && done !== 1'b1 && cnt < 200) begin
            if (cnt == 3) begin
                n_checks++;
                if (play_octave !== 3'd1 || play_note !== 4'd0) begin
                    n_fail++;
                    $display("FAIL rest_latched: oct=%0d note=%0d, want 1 0", play_octave, play_note);
                end
            end
            cnt++;
            tick;
        end
        n_checks++;
        if (cnt != 19) begin
            n_fail++;
            $display("FAIL rest_silent_len: %0d cycles before 2nd tone, want 19", cnt);
        end
        n_checks++;
        if (play_octave !== 3'd4 || play_note !== 4'd3) begin
            n_fail++;
            $display("FAIL min_note_vals: oct=%0d note=%0d, want 4 3", play_octave, play_note);
        end
        cnt = 0;
        while (tone_en === 1'b1 && cnt < 100) begin
            cnt++;
            tick;
        end
        n_checks++;
        if (cnt != 4) begin
            n_fail++;
            $display("FAIL min_dur_clamp: %0d cycles, want 4", cnt);
        end
        cnt = 0;
        while (done !== 1'b1 && cnt < 100) begin
            cnt++;
            tick;
        end
        n_checks++;
        if (cnt != 5) begin
            n_fail++;
            $display("FAIL rest_min_done: %0d cycles to done, want 5", cnt);
        end
        tick;
        $display("test_rest_min: complete");
    endtask

    task automatic test_empty;
        pulse_start(0);
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b1 || rec.en !== 1'b0) begin
            n_fail++;
            $display("FAIL empty_fin: done=%b busy=%b en=%b, want 1 1 0", done, busy, rec.en);
        end
        tick;
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0 || rec.en !== 1'b0) begin
            n_fail++;
            $display("FAIL empty_idle: done=%b busy=%b en=%b, want 0 0 0", done, busy, rec.en);
        end
        $display("test_empty: complete");
    endtask

    task automatic test_full;
        int exp_idx;
        int exp_note;
        int cyc;
        logic prev_en;
        logic prev_tone;
        for (int i = 0; i < DEPTH; i++) begin
            set_entry(REC_CNT_BITS'(i), OCTAVE_BITS'(i), NOTE_BITS'(i + 1), LENGTH_BITS'(4), FULL_NOTE_BITS'(16));
        end
        pulse_start((REC_CNT_BITS + 1)'(DEPTH));
        exp_idx = 0;
        exp_note = 1;
        cyc = 0;
        prev_en = 1'b0;
        prev_tone = 1'b0;
        while (done !== 1'b1 && cyc < 400) begin
            if (rec.en === 1'b1 && prev_en !== 1'b1) begin
                n_checks++;
                if (rec.cnt !== REC_CNT_BITS'(exp_idx)) begin
                    n_fail++;
                    $display("FAIL full_cnt[%0d]: rec_cnt=%0d, want %0d", exp_idx, rec.cnt, exp_idx);
                end
                exp_idx++;
            end
            if (tone_en === 1'b1 && prev_tone !== 1'b1) begin
                n_checks++;
                if (play_note !== NOTE_BITS'(exp_note)) begin
                    n_fail++;
                    $display("FAIL full_note[%0d]: note=%0d, want %0d", exp_note - 1, play_note, exp_note);
                end
                exp_note++;
            end
            prev_en = rec.en;
            prev_tone = tone_en;
            cyc++;
            tick;
        end
        n_checks++;
        if (exp_idx != DEPTH || exp_note != DEPTH + 1 || done !== 1'b1) begin
            n_fail++;
            $display("FAIL full_count: fetches=%0d notes=%0d done=%b, want %0d %0d 1",
                     exp_idx, exp_note - 1, done, DEPTH, DEPTH);
        end
        tick;
        $display("test_full: complete");
    endtask

    task automatic test_abort;
        int cyc;
        int hits;
        set_entry(0, 1, 7, 2, 16);
        set_entry(1, 2, 8, 2, 16);
        set_entry(2, 3, 9, 2, 16);
        pulse_start(3);
        cyc = 0;
        while (!(tone_en === 1'b1 && play_note === 4'd8) && cyc < 200) begin
            cyc++;
            tick;
        end
        n_checks++;
        if (cyc >= 200) begin
            n_fail++;
            $display("FAIL abort_reach_note2: note 8 never played, want it within 200 cycles");
        end
        tick;
        tick;
        stop = 1'b1;
        tick;
        stop = 1'b0;
        n_checks++;
        if ({busy, tone_en, done, rec.en} !== 4'b0 || play_note !== '0 || play_octave !== '0 || rec.cnt !== '0) begin
            n_fail++;
            $display("FAIL abort_idle: busy=%b tone=%b done=%b en=%b oct=%0d note=%0d cnt=%0d, want all 0",
                     busy, tone_en, done, rec.en, play_octave, play_note, rec.cnt);
        end
        hits = 0;
        for (int i = 0; i < 30; i++) begin
            if (done === 1'b1 || busy === 1'b1) hits++;
            tick;
        end
        n_checks++;
        if (hits != 0) begin
            n_fail++;
            $display("FAIL abort_quiet: %0d busy/done cycles after stop, want 0", hits);
        end
        pulse_start(3);
        cyc = 0;
        while (tone_en !== 1'b1 && cyc < 50) begin
            cyc++;
            tick;
        end
        n_checks++;
        if (tone_en !== 1'b1 || play_note !== 4'd7 || play_octave !== 3'd1) begin
            n_fail++;
            $display("FAIL abort_replay: tone=%b oct=%0d note=%0d, want 1 1 7", tone_en, play_octave, play_note);
        end
        stop = 1'b1;
        tick;
        stop = 1'b0;
        $display("test_abort: complete");
    endtask

    task automatic test_busy_start;
        int cyc;
        int tone_hi;
        int rises;
        logic prev_tone;
        set_entry(0, 2, 5, 2, 16);
        set_entry(1, 3, 6, 4, 16);
        pulse_start(2);
        cyc = 0;
        tone_hi = 0;
        rises = 0;
        prev_tone = 1'b0;
        while (done !== 1'b1 && cyc < 200) begin
            if (cyc == 5) begin
                rec_len = 1;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (tone_en === 1'b1) tone_hi++;
            if (tone_en === 1'b1 && prev_tone !== 1'b1) rises++;
            prev_tone = tone_en;
            cyc++;
            tick;
        end
        start = 1'b0;
        n_checks++;
        if (tone_hi != 20 || rises != 2 || done !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_start_ignored: tone cycles=%0d notes=%0d done=%b, want 20 2 1",
                     tone_hi, rises, done);
        end
        tick;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_start_end: busy=%b done=%b, want 0 0", busy, done);
        end
        $display("test_busy_start: complete");
    endtask

    task automatic test_start_stop;
        rec_len = 2;
        start = 1'b1;
        stop = 1'b1;
        tick;
        start = 1'b0;
        stop = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || rec.en !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL start_stop_same: busy=%b en=%b done=%b, want 0 0 0", busy, rec.en, done);
        end
        tick;
        tick;
        n_checks++;
        if (busy !== 1'b0 || rec.en !== 1'b0) begin
            n_fail++;
            $display("FAIL start_stop_stays_idle: busy=%b en=%b, want 0 0", busy, rec.en);
        end
        $display("test_start_stop: complete");
    endtask

    task automatic test_async_reset;
        int cyc;
        set_entry(0, 2, 5, 2, 16);
        pulse_start(1);
        cyc = 0;
        while (tone_en !== 1'b1 && cyc < 50) begin
            cyc++;
            tick;
        end
        tick;
        n_checks++;
        if (tone_en !== 1'b1) begin
            n_fail++;
            $display("FAIL async_reset_setup: tone=%b, want 1 before reset", tone_en);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({tone_en, rec.en, busy, done} !== 4'b0 || play_octave !== '0 || play_note !== '0) begin
            n_fail++;
            $display("FAIL async_reset_drop: tone=%b en=%b busy=%b done=%b oct=%0d note=%0d, want all 0",
                     tone_en, rec.en, busy, done, play_octave, play_note);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick;
        tick;
        n_checks++;
        if (busy !== 1'b0 || tone_en !== 1'b0 || rec.en !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset_idle: busy=%b tone=%b en=%b, want 0 0 0", busy, tone_en, rec.en);
        end
        $display("test_async_reset: complete");
    endtask

    initial begin
        test_reset;
        test_single_note;
        test_rest_min;
        test_empty;
        test_full;
        test_abort;
        test_busy_start;
        test_start_stop;
        test_async_reset;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
